// File: rtl/decode.sv
// decode: LC3 instruction decode stage.
// Latches the fetched instruction once program memory data is valid, splits
// it into register/immediate/branch fields, starts execute with a one-cycle
// pulse and requests the next fetch after execute retires the instruction.
module decode #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        decode_start,
  input  logic [15:0] pc_in,
  input  logic [15:0] mem_dout,
  input  logic        exe_done,
  output logic        fetch_start_out,
  output logic        exe_start,
  output logic [15:0] ir_out,
  output logic [3:0]  opcode_out,
  output logic [2:0]  dr_out,
  output logic [2:0]  sr1_out,
  output logic [2:0]  sr2_out,
  output logic        imm_mode_out,
  output logic [8:0]  offset9_out,
  output logic [2:0]  br_nzp_out,
  output logic [15:0] imm_out,
  output logic [15:0] npc_out,
  output logic        illegal_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_IDLE  = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_EXEC  = 3'd4,
    S_DONE  = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  localparam logic [1:0] LAT = MEM_LATENCY[1:0];

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_RSV  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [15:0] r_ir;
  logic [15:0] r_pc;
  logic        r_illegal;
  logic        r_exe_start;
  logic        r_fetch_start;
  logic        r_busy;
  logic [15:0] w_imm;

  // RTI is not supported by this core and 1101 is reserved.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op == OP_RTI) || (op == OP_RSV);
  endfunction

  // Control FSM with registered pulse/busy outputs and IR/PC capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BOOT;
      r_cnt         <= 2'd0;
      r_ir          <= 16'h0000;
      r_pc          <= 16'h0000;
      r_illegal     <= 1'b0;
      r_exe_start   <= 1'b0;
      r_fetch_start <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      r_exe_start   <= 1'b0;
      r_fetch_start <= 1'b0;
      case (r_state)
        S_BOOT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_IDLE: begin
          if (decode_start) begin
            r_pc    <= pc_in;
            r_cnt   <= LAT;
            r_state <= S_WAIT;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 2'd1;
          // Count of 1 (or a stray 0) means memory data is valid on this edge.
          if (r_cnt <= 2'd1) begin
            r_ir <= mem_dout;
            if (is_illegal_op(mem_dout[15:12])) begin
              r_state   <= S_HALT;
              r_illegal <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_state     <= S_ISSUE;
              r_exe_start <= 1'b1;
            end
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_ISSUE: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (exe_done) begin
            r_state       <= S_DONE;
            r_fetch_start <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_HALT: begin
          r_state <= S_HALT;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_BOOT;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Opcode-selected immediate extension of the latched instruction.
  always_comb begin
    w_imm = 16'h0000;
    case (r_ir[15:12])
      OP_ADD, OP_AND:
        w_imm = {{11{r_ir[4]}}, r_ir[4:0]};
      OP_BR, OP_LD, OP_LDI, OP_ST, OP_STI, OP_LEA:
        w_imm = {{7{r_ir[8]}}, r_ir[8:0]};
      OP_LDR, OP_STR:
        w_imm = {{10{r_ir[5]}}, r_ir[5:0]};
      OP_JSR: begin
        if (r_ir[11]) begin
          w_imm = {{5{r_ir[10]}}, r_ir[10:0]};
        end else begin
          w_imm = 16'h0000;
        end
      end
      OP_TRAP:
        w_imm = {8'h00, r_ir[7:0]};
      default:
        w_imm = 16'h0000;
    endcase
  end

  // The boot fetch request is held in a register that resets high; gating
  // with rst_n keeps it quiet while reset is asserted.
  assign fetch_start_out = r_fetch_start & rst_n;
  assign exe_start       = r_exe_start;
  assign busy            = r_busy;
  assign illegal_out     = r_illegal;

  assign ir_out       = r_ir;
  assign opcode_out   = r_ir[15:12];
  assign dr_out       = r_ir[11:9];
  assign sr1_out      = r_ir[8:6];
  assign sr2_out      = r_ir[2:0];
  assign imm_mode_out = r_ir[5];
  assign offset9_out  = r_ir[8:0];
  assign br_nzp_out   = r_ir[11:9];
  assign imm_out      = w_imm;
  assign npc_out      = r_pc + 16'd1;

endmodule

// File: tb/tb_decode.sv
// tb_decode: self-checking bench for the LC3 decode stage.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        decode_start = 1'b0;
  logic        exe_done = 1'b0;
  logic        ds3 = 1'b0;
  logic        ed3 = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic [15:0] mem_dout = 16'h0000;

  logic        fetch_start_out, exe_start, imm_mode_out, illegal_out, busy;
  logic [15:0] ir_out, imm_out, npc_out;
  logic [3:0]  opcode_out;
  logic [2:0]  dr_out, sr1_out, sr2_out, br_nzp_out;
  logic [8:0]  offset9_out;

  logic        fetch3, exe3, immm3, ill3, busy3;
  logic [15:0] ir3, imm3, npc3;
  logic [3:0]  op3;
  logic [2:0]  dr3, s13, s23, nzp3;
  logic [8:0]  off3;

  int n_pass = 0;
  int n_total = 0;

  decode #(.MEM_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .decode_start(decode_start), .pc_in(pc_in),
    .mem_dout(mem_dout), .exe_done(exe_done), .fetch_start_out(fetch_start_out),
    .exe_start(exe_start), .ir_out(ir_out), .opcode_out(opcode_out),
    .dr_out(dr_out), .sr1_out(sr1_out), .sr2_out(sr2_out),
    .imm_mode_out(imm_mode_out), .offset9_out(offset9_out),
    .br_nzp_out(br_nzp_out), .imm_out(imm_out), .npc_out(npc_out),
    .illegal_out(illegal_out), .busy(busy)
  );

  decode #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .decode_start(ds3), .pc_in(pc_in),
    .mem_dout(mem_dout), .exe_done(ed3), .fetch_start_out(fetch3),
    .exe_start(exe3), .ir_out(ir3), .opcode_out(op3),
    .dr_out(dr3), .sr1_out(s13), .sr2_out(s23),
    .imm_mode_out(immm3), .offset9_out(off3),
    .br_nzp_out(nzp3), .imm_out(imm3), .npc_out(npc3),
    .illegal_out(ill3), .busy(busy3)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] sext_ref(input int unsigned raw, input int bits);
    int v;
    v = int'(raw % (32'd1 << bits));
    if (v >= (1 << (bits - 1))) v = v - (1 << bits);
    return 16'(v);
  endfunction

  function automatic logic [15:0] imm_ref(input logic [15:0] ir);
    int unsigned u;
    int unsigned op;
    u  = 32'(ir);
    op = u / 4096;
    case (op)
      1, 5:                 return sext_ref(u, 5);
      0, 2, 3, 10, 11, 14:  return sext_ref(u, 9);
      6, 7:                 return sext_ref(u, 6);
      4:                    return (((u / 2048) % 2) == 1) ? sext_ref(u, 11) : 16'h0000;
      15:                   return 16'(u % 256);
      default:              return 16'h0000;
    endcase
  endfunction

  // {opcode, dr, sr1, sr2, imm_mode, offset9, nzp}
  function automatic logic [25:0] fields_ref(input logic [15:0] ir);
    int unsigned u;
    u = 32'(ir);
    return {4'(u / 4096), 3'((u / 512) % 8), 3'((u / 64) % 8), 3'(u % 8),
            1'((u / 32) % 2), 9'(u % 512), 3'((u / 512) % 8)};
  endfunction

  // ---------------- drivers ----------------
  task automatic run_instr(input logic [15:0] pc, input logic [15:0] instr, output int lat);
    @(negedge clk);
    decode_start = 1'b1;
    pc_in = pc;
    mem_dout = instr;
    @(negedge clk);
    decode_start = 1'b0;
    lat = 0;
    while (exe_start !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (exe_start !== 1'b1) lat = -1;
  endtask

  task automatic finish_instr(output logic f_next, output logic f_after);
    exe_done = 1'b1;
    @(negedge clk);
    exe_done = 1'b0;
    f_next = fetch_start_out;
    @(negedge clk);
    f_after = fetch_start_out;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_total++;
    if ({fetch_start_out, exe_start, busy, illegal_out, ir_out, imm_out, npc_out} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001})
      $display("FAIL reset_held: got fs=%b es=%b busy=%b ill=%b ir=%h imm=%h npc=%h",
               fetch_start_out, exe_start, busy, illegal_out, ir_out, imm_out, npc_out);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({fetch_start_out, exe_start, busy, npc_out, opcode_out, dr_out} !==
        {1'b1, 1'b0, 1'b0, 16'h0001, 4'h0, 3'd0})
      $display("FAIL reset_boot: got fs=%b es=%b busy=%b npc=%h, want fs=1 es=0 busy=0 npc=0001",
               fetch_start_out, exe_start, busy, npc_out);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (fetch_start_out !== 1'b0) $display("FAIL reset_pulse_width: fs=%b want 0", fetch_start_out);
    else n_pass++;
  endtask

  task automatic test_add;
    int lat;
    logic f1, f2;
    run_instr(16'h3000, 16'h1A7F, lat);
    n_total++;
    if (lat !== 1) $display("FAIL add_latency: got %0d want 1", lat);
    else n_pass++;
    n_total++;
    if ({opcode_out, dr_out, sr1_out, imm_mode_out} !== {4'h1, 3'd5, 3'd1, 1'b1})
      $display("FAIL add_fields: got op=%h dr=%0d sr1=%0d im=%b want 1/5/1/1",
               opcode_out, dr_out, sr1_out, imm_mode_out);
    else n_pass++;
    n_total++;
    if ({imm_out, npc_out} !== {16'hFFFF, 16'h3001})
      $display("FAIL add_imm_npc: got imm=%h npc=%h want FFFF 3001", imm_out, npc_out);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({exe_start, busy} !== 2'b01) $display("FAIL add_exec: got es=%b busy=%b want 0 1", exe_start, busy);
    else n_pass++;
    finish_instr(f1, f2);
    n_total++;
    if ({f1, f2, busy} !== 3'b100) $display("FAIL add_fetch: got %b%b busy=%b want 10 busy 0", f1, f2, busy);
    else n_pass++;
  endtask

  task automatic test_sequence;
    logic [15:0] instrs [4] = '{16'h05FE, 16'h64DF, 16'hF025, 16'h4FFF};
    logic [15:0] imms   [4] = '{16'hFFFE, 16'h001F, 16'h0025, 16'hFFFF};
    int lat;
    logic f1, f2;
    for (int i = 0; i < 4; i++) begin
      run_instr(16'h3001 + 16'(i), instrs[i], lat);
      n_total++;
      if (lat !== 1 || imm_out !== imms[i])
        $display("FAIL seq_imm[%0d]: got lat=%0d imm=%h want 1 %h", i, lat, imm_out, imms[i]);
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if ({br_nzp_out, offset9_out} !== {3'b010, 9'h1FE})
          $display("FAIL seq_br_fields: got nzp=%b off=%h want 010 1FE", br_nzp_out, offset9_out);
        else n_pass++;
      end
      @(negedge clk);
      finish_instr(f1, f2);
      n_total++;
      if ({f1, f2} !== 2'b10) $display("FAIL seq_fetch[%0d]: got %b%b want 10", i, f1, f2);
      else n_pass++;
    end
  endtask

  task automatic test_pc_wrap;
    int lat;
    logic f1, f2;
    run_instr(16'hFFFF, 16'h0E01, lat);
    n_total++;
    if (lat !== 1 || npc_out !== 16'h0000)
      $display("FAIL pc_wrap: got lat=%0d npc=%h want 1 0000", lat, npc_out);
    else n_pass++;
    @(negedge clk);
    finish_instr(f1, f2);
  endtask

  task automatic test_random;
    int lat;
    logic f1, f2;
    logic [15:0] instr, pc;
    for (int i = 0; i < 24; i++) begin
      do instr = 16'($urandom_range(0, 65535));
      while (instr[15:12] == 4'h8 || instr[15:12] == 4'hD);
      pc = 16'($urandom_range(0, 65535));
      run_instr(pc, instr, lat);
      n_total++;
      if (lat !== 1 || ir_out !== instr || npc_out !== pc + 16'd1 || imm_out !== imm_ref(instr) ||
          {opcode_out, dr_out, sr1_out, sr2_out, imm_mode_out, offset9_out, br_nzp_out} !== fields_ref(instr))
        $display("FAIL rand[%0d]: ir=%h pc=%h got lat=%0d imm=%h npc=%h want imm=%h npc=%h",
                 i, instr, pc, lat, imm_out, npc_out, imm_ref(instr), pc + 16'd1);
      else n_pass++;
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
      finish_instr(f1, f2);
      n_total++;
      if ({f1, f2} !== 2'b10) $display("FAIL rand_fetch[%0d]: got %b%b want 10", i, f1, f2);
      else n_pass++;
    end
  endtask

  task automatic test_extra_start;
    int lat;
    logic f1, f2;
    run_instr(16'h1234, 16'h5A23, lat);
    @(negedge clk);
    decode_start = 1'b1;
    pc_in = 16'h7777;
    mem_dout = 16'h1111;
    @(negedge clk);
    decode_start = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({ir_out, npc_out, exe_start, busy} !== {16'h5A23, 16'h1235, 1'b0, 1'b1})
      $display("FAIL extra_start: got ir=%h npc=%h es=%b busy=%b want 5A23 1235 0 1",
               ir_out, npc_out, exe_start, busy);
    else n_pass++;
    finish_instr(f1, f2);
    n_total++;
    if ({f1, f2} !== 2'b10) $display("FAIL extra_fetch: got %b%b want 10", f1, f2);
    else n_pass++;
  endtask

  task automatic test_latency3;
    int lat;
    logic f1;
    @(negedge clk);
    ds3 = 1'b1;
    pc_in = 16'h0200;
    mem_dout = 16'h2A05;
    @(negedge clk);
    ds3 = 1'b0;
    lat = 0;
    while (exe3 !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    n_total++;
    if (exe3 !== 1'b1 || lat !== 3 || ir3 !== 16'h2A05 || imm3 !== 16'h0005)
      $display("FAIL lat3: got lat=%0d ir=%h imm=%h want 3 2A05 0005", lat, ir3, imm3);
    else n_pass++;
    @(negedge clk);
    ed3 = 1'b1;
    @(negedge clk);
    ed3 = 1'b0;
    f1 = fetch3;
    n_total++;
    if (f1 !== 1'b1) $display("FAIL lat3_fetch: got %b want 1", f1);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_in_exec;
    int lat;
    int pulses;
    run_instr(16'h4444, 16'h1261, lat);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({exe_start, fetch_start_out, busy, illegal_out, ir_out, npc_out} !==
        {1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001})
      $display("FAIL rst_exec: got es=%b fs=%b busy=%b ir=%h npc=%h want 0 0 0 0000 0001",
               exe_start, fetch_start_out, busy, ir_out, npc_out);
    else n_pass++;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (fetch_start_out === 1'b1) pulses++;
    end
    n_total++;
    if (pulses !== 1) $display("FAIL rst_exec_fetch: got %0d pulses want 1", pulses);
    else n_pass++;
  endtask

  task automatic test_illegal(input logic [15:0] instr);
    int lat;
    int seen;
    run_instr(16'h5000, instr, lat);
    n_total++;
    if (lat !== -1 || illegal_out !== 1'b1 || busy !== 1'b0 || ir_out !== instr)
      $display("FAIL illegal_%h: got lat=%0d ill=%b busy=%b ir=%h want -1 1 0", instr, lat, illegal_out, busy, ir_out);
    else n_pass++;
    seen = 0;
    decode_start = 1'b1;
    mem_dout = 16'h1A7F;
    @(negedge clk);
    decode_start = 1'b0;
    exe_done = 1'b1;
    @(negedge clk);
    exe_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (exe_start === 1'b1 || fetch_start_out === 1'b1) seen++;
      @(negedge clk);
    end
    n_total++;
    if (seen !== 0 || illegal_out !== 1'b1 || ir_out !== instr)
      $display("FAIL halt_sticky_%h: got pulses=%0d ill=%b ir=%h want 0 1 %h", instr, seen, illegal_out, ir_out, instr);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sequence();
    test_pc_wrap();
    test_random();
    test_extra_start();
    test_latency3();
    test_reset_in_exec();
    test_illegal(16'hD000);
    test_reset();
    test_illegal(16'h8123);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
